// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD cook timer.
package timer_pkg;

  localparam int unsigned BCD_W       = 4;
  localparam int unsigned BCD_MAX_MOD = 10;
  localparam logic [15:0] DIG_MOD_MMSS = 16'hA_A_6_A;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_e;

  // Limit an entered digit to the largest legal value for its modulus.
  function automatic bcd_t clamp_digit(bcd_t v, int unsigned mod);
    return (32'(v) >= mod) ? BCD_W'(mod - 1) : v;
  endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Control/status bundle between keypad logic, display and the cook timer.
// BCD_TIMER_UP_MODE_EN adds the 'up' direction select.
interface bcd_down_timer_if #(
  parameter int unsigned NDIG = 4
);
  logic                tick;
  logic                load;
  logic [4*NDIG-1:0]   data;
  logic                start;
  logic                pause;
`ifdef BCD_TIMER_UP_MODE_EN
  logic                up;
`endif
  logic [4*NDIG-1:0]   count;
  logic                zero;
  logic                done;
  logic                running;
  logic [1:0]          state;

  modport master (
`ifdef BCD_TIMER_UP_MODE_EN
    output up,
`endif
    output tick, load, data, start, pause,
    input  count, zero, done, running, state
  );

  modport slave (
`ifdef BCD_TIMER_UP_MODE_EN
    input  up,
`endif
    input  tick, load, data, start, pause,
    output count, zero, done, running, state
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD digit with programmable modulus; steps down (dir=0) or up (dir=1).
module bcd_digit_cell
  import timer_pkg::*;
#(
  parameter int unsigned MOD = BCD_MAX_MOD
) (
  input  logic clk,
  input  logic clrn,
  input  logic load,
  input  bcd_t ld_val,
  input  logic step,
  input  logic dir,
  output bcd_t digit,
  output logic is_zero,
  output logic is_max,
  output logic bout
);

  localparam bcd_t TOP = BCD_W'(MOD - 1);

  bcd_t digit_q, digit_d;

  // Next digit value: load wins, otherwise step with wrap at the boundary.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = ld_val;
    end else if (step) begin
      if (dir) digit_d = is_max  ? '0  : digit_q + BCD_W'(1);
      else     digit_d = is_zero ? TOP : digit_q - BCD_W'(1);
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) digit_q <= '0;
    else       digit_q <= digit_d;
  end

  assign digit   = digit_q;
  assign is_zero = (digit_q == '0);
  assign is_max  = (digit_q == TOP);
  // Borrow (down) or carry (up) into the next digit.
  assign bout    = step & (dir ? is_max : is_zero);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer (default MM:SS) with IDLE/RUN/PAUSE/DONE control.
// BCD_TIMER_UP_MODE_EN enables count-up operation selected by bus.up at start.
module bcd_down_timer
  import timer_pkg::*;
#(
  parameter int unsigned       NDIG    = 4,
  parameter logic [4*NDIG-1:0] DIG_MOD = (4*NDIG)'(DIG_MOD_MMSS)
) (
  input  logic clk,
  input  logic clrn,
  bcd_down_timer_if.slave bus
);

  localparam bcd_t LAST_UP0 = BCD_W'(32'(DIG_MOD[3:0]) - 2);

  bcd_t              digit [NDIG];
  logic [NDIG-1:0]   is_zero, is_max, bout;
  logic [4*NDIG-1:0] count_c;
  logic              zero_c, all_max_c, last_dn_c, last_up_c, last_c;
  logic              step_en, dir, blk_idle, blk_pause;

  timer_state_e state_q, state_d;
  logic         done_q, done_d;
  logic         running_q, running_d;
  logic         dir_q, dir_d;

  // Digit chain: each digit steps only when all lower digits borrow/carry.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam int unsigned MOD_I = 32'(DIG_MOD[4*i +: 4]);
    bcd_t ld_val;
    logic step_in;
    assign ld_val = clamp_digit(bus.data[4*i +: 4], MOD_I);
    if (i == 0) begin : g_first
      assign step_in = step_en;
    end else begin : g_rest
      assign step_in = bout[i-1];
    end
    bcd_digit_cell #(.MOD(MOD_I)) u_cell (
      .clk     (clk),
      .clrn    (clrn),
      .load    (bus.load),
      .ld_val  (ld_val),
      .step    (step_in),
      .dir     (dir),
      .digit   (digit[i]),
      .is_zero (is_zero[i]),
      .is_max  (is_max[i]),
      .bout    (bout[i])
    );
  end

  // Flatten digits and detect the value one step before the terminal count.
  always_comb begin
    logic up_zero, up_max;
    count_c = '0;
    up_zero = 1'b1;
    up_max  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      count_c[4*i +: 4] = digit[i];
      if (i > 0) begin
        up_zero = up_zero & is_zero[i];
        up_max  = up_max & is_max[i];
      end
    end
    zero_c    = &is_zero;
    all_max_c = &is_max;
    last_dn_c = up_zero && (digit[0] == BCD_W'(1));
    last_up_c = up_max && (digit[0] == LAST_UP0);
  end

`ifdef BCD_TIMER_UP_MODE_EN
  assign dir       = dir_q;
  assign blk_idle  = bus.up ? all_max_c : zero_c;
  assign blk_pause = dir_q ? all_max_c : zero_c;
  assign last_c    = dir_q ? last_up_c : last_dn_c;
`else
  wire unused_up = all_max_c ^ last_up_c;
  assign dir       = 1'b0;
  assign blk_idle  = zero_c;
  assign blk_pause = zero_c;
  assign last_c    = last_dn_c;
`endif

  // Control FSM next state; priority load > start > pause > tick.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    step_en = 1'b0;
    if (bus.load) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start && !blk_idle) begin
          state_d = RUN;
`ifdef BCD_TIMER_UP_MODE_EN
          dir_d   = bus.up;
`endif
        end
        PAUSE: if (bus.start && !blk_pause) state_d = RUN;
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (bus.tick) begin
            step_en = 1'b1;
            if (last_c) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  // Control registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      running_q <= running_d;
      dir_q     <= dir_d;
    end
  end

  assign bus.count   = count_c;
  assign bus.zero    = zero_c;
  assign bus.done    = done_q;
  assign bus.running = running_q;
  assign bus.state   = state_q;

endmodule
